// File: rtl/control_conv.sv
// ---------------------------------------------------------------------------
// control_conv
//
// Top-level sequencer for the 1-D convolution engine.
// It first gives the X and F loaders write access to their memories. Once both
// loaders report done, it pulses a wrap to reset their address counters. It
// then computes every output position by sweeping read addresses over both
// memories and steering the accumulator. Each finished output is offered on a
// valid/ready handshake.
//
// Ports:
//   clk, reset_n   clock (rising edge) and asynchronous active-low reset
//   done_x/done_f  loaders have finished writing X samples / F taps
//   mem_wr_state   loaders may write (LOAD only)
//   mem_wr_done    one-cycle pulse wrapping both loader address counters
//   addr_x/addr_f  X / F memory read addresses
//   clr_acc/en_acc accumulator load-first-product / capture-product strobes
//   m_valid_y      accumulator holds finished output y[y_idx]
//   m_ready_y      downstream accepts the presented output
//   y_idx          index j of the output being presented
//   conv_done      high in the cycle the last output is accepted
// ---------------------------------------------------------------------------
module control_conv #(
    parameter int INPUT_N     = 16,
    parameter int LG_INPUT_N  = 4,
    parameter int FILTER_N    = 8,
    parameter int LG_FILTER_N = 3
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   done_x,
    input  logic                   done_f,
    output logic                   mem_wr_state,
    output logic                   mem_wr_done,
    output logic [LG_INPUT_N-1:0]  addr_x,
    output logic [LG_FILTER_N-1:0] addr_f,
    output logic                   clr_acc,
    output logic                   en_acc,
    output logic                   m_valid_y,
    input  logic                   m_ready_y,
    output logic [LG_INPUT_N-1:0]  y_idx,
    output logic                   conv_done
);

    localparam int OUT_N = INPUT_N - FILTER_N + 1;

    localparam logic [LG_INPUT_N-1:0]  J_LAST = LG_INPUT_N'(OUT_N - 1);
    localparam logic [LG_FILTER_N-1:0] K_LAST = LG_FILTER_N'(FILTER_N - 1);
    localparam logic [LG_INPUT_N-1:0]  X_ONE  = LG_INPUT_N'(1);
    localparam logic [LG_FILTER_N-1:0] F_ONE  = LG_FILTER_N'(1);

    typedef enum logic [2:0] {
        LOAD,
        WRAP,
        COMPUTE,
        DRAIN,
        OUT
    } state_e;

    state_e                 state_q, state_d;
    logic [LG_INPUT_N-1:0]  j_q, j_d;
    logic [LG_FILTER_N-1:0] k_q, k_d;
    logic [LG_INPUT_N-1:0]  addr_x_q, addr_x_d;
    logic [LG_FILTER_N-1:0] addr_f_q, addr_f_d;
    logic                   rd_vld_q;
    logic                   first_q;

    // The address registers are loaded one edge ahead so that, throughout
    // COMPUTE, addr_f equals k and addr_x equals j+k. Outside COMPUTE they
    // keep their last value, so DRAIN and OUT issue no new reads.
    always_comb begin
        state_d  = state_q;
        j_d      = j_q;
        k_d      = k_q;
        addr_x_d = addr_x_q;
        addr_f_d = addr_f_q;
        case (state_q)
            LOAD: begin
                if (done_x && done_f) begin
                    state_d = WRAP;
                end
            end
            WRAP: begin
                state_d  = COMPUTE;
                j_d      = '0;
                k_d      = '0;
                addr_x_d = '0;
                addr_f_d = '0;
            end
            COMPUTE: begin
                if (k_q == K_LAST) begin
                    state_d = DRAIN;
                    k_d     = '0;
                end else begin
                    k_d      = k_q + F_ONE;
                    addr_f_d = addr_f_q + F_ONE;
                    addr_x_d = addr_x_q + X_ONE;
                end
            end
            DRAIN: begin
                state_d = OUT;
            end
            OUT: begin
                if (m_ready_y) begin
                    if (j_q == J_LAST) begin
                        state_d = LOAD;
                        j_d     = '0;
                    end else begin
                        state_d  = COMPUTE;
                        j_d      = j_q + X_ONE;
                        addr_x_d = j_q + X_ONE;
                        addr_f_d = '0;
                    end
                end
            end
            default: begin
                state_d = LOAD;
            end
        endcase
    end

    // The memory has one cycle of read latency, so the accumulator strobes
    // are delayed copies of "a read was issued" and "that read was tap 0".
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= LOAD;
            j_q      <= '0;
            k_q      <= '0;
            addr_x_q <= '0;
            addr_f_q <= '0;
            rd_vld_q <= 1'b0;
            first_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            j_q      <= j_d;
            k_q      <= k_d;
            addr_x_q <= addr_x_d;
            addr_f_q <= addr_f_d;
            rd_vld_q <= (state_q == COMPUTE);
            first_q  <= (state_q == COMPUTE) && (k_q == '0);
        end
    end

    assign mem_wr_state = (state_q == LOAD);
    assign mem_wr_done  = (state_q == WRAP);
    assign addr_x       = addr_x_q;
    assign addr_f       = addr_f_q;
    assign en_acc       = rd_vld_q;
    assign clr_acc      = first_q;
    assign m_valid_y    = (state_q == OUT);
    assign y_idx        = j_q;

    // This pulse coincides with the accepting handshake of the final output.
    assign conv_done    = (state_q == OUT) && m_ready_y && (j_q == J_LAST);

endmodule
